// File: rtl/gpu_instruction_dispatch_if.sv
// Dispatch bus: FIFO head fields and pop strobe, engine start/done, registered command.
// The slave modport is the dispatch side; the master modport is the FIFO/engine side.
interface gpu_instruction_dispatch_if #(
    parameter int W_BITS   = 10,
    parameter int H_BITS   = 10,
    parameter int C_BITS   = 8,
    parameter int CNT_BITS = 16
);
    logic                fifo_empty_i;
    logic [3:0]          opcode_i;
    logic [W_BITS-1:0]   x1_i;
    logic [W_BITS-1:0]   x2_i;
    logic [H_BITS-1:0]   y1_i;
    logic [H_BITS-1:0]   y2_i;
    logic [W_BITS-1:0]   rad_i;
    logic [C_BITS-1:0]   r_i;
    logic [C_BITS-1:0]   g_i;
    logic [C_BITS-1:0]   b_i;
    logic [2:0]          quad_i;
    logic                stall_i;
    logic                pop_instruction_o;
    logic [2:0]          start_o;
    logic [2:0]          done_i;
    logic [W_BITS-1:0]   cmd_x1_o;
    logic [W_BITS-1:0]   cmd_x2_o;
    logic [H_BITS-1:0]   cmd_y1_o;
    logic [H_BITS-1:0]   cmd_y2_o;
    logic [W_BITS-1:0]   cmd_rad_o;
    logic [C_BITS-1:0]   cmd_r_o;
    logic [C_BITS-1:0]   cmd_g_o;
    logic [C_BITS-1:0]   cmd_b_o;
    logic [2:0]          cmd_quad_o;
    logic                busy_o;
    logic                illegal_o;
    logic [CNT_BITS-1:0] done_count_o;

    modport slave (
        input  fifo_empty_i, opcode_i, x1_i, x2_i, y1_i, y2_i, rad_i,
        input  r_i, g_i, b_i, quad_i, stall_i, done_i,
        output pop_instruction_o, start_o, cmd_x1_o, cmd_x2_o,
        output cmd_y1_o, cmd_y2_o, cmd_rad_o, cmd_r_o, cmd_g_o,
        output cmd_b_o, cmd_quad_o, busy_o, illegal_o, done_count_o
    );

    modport master (
        output fifo_empty_i, opcode_i, x1_i, x2_i, y1_i, y2_i, rad_i,
        output r_i, g_i, b_i, quad_i, stall_i, done_i,
        input  pop_instruction_o, start_o, cmd_x1_o, cmd_x2_o,
        input  cmd_y1_o, cmd_y2_o, cmd_rad_o, cmd_r_o, cmd_g_o,
        input  cmd_b_o, cmd_quad_o, busy_o, illegal_o, done_count_o
    );
endinterface

// File: rtl/gpu_instruction_dispatch.sv
// Pops one instruction from the FIFO, decodes and normalises it, then issues it
// to the line/arc/fill raster engine and waits for that engine's done pulse.
module gpu_instruction_dispatch #(
    parameter int W_BITS   = 10,
    parameter int H_BITS   = 10,
    parameter int C_BITS   = 8,
    parameter int CNT_BITS = 16
) (
    input logic                       clk,
    input logic                       rst,
    gpu_instruction_dispatch_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE, S_DECODE, S_ISSUE, S_BUSY
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_FILL = 4'b0001;
    localparam logic [3:0] OP_ARC  = 4'b0010;
    localparam logic [3:0] OP_LINE = 4'b0100;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_op;
    logic [W_BITS-1:0]   r_x1, r_x2, r_rad;
    logic [H_BITS-1:0]   r_y1, r_y2;
    logic [C_BITS-1:0]   r_r, r_g, r_b;
    logic [2:0]          r_quad;
    logic [CNT_BITS-1:0] r_cnt;

    logic [2:0] w_eng;
    logic       w_nop;
    logic       w_take;
    logic       w_done;
    logic       w_pop;
    logic [2:0] w_start;
    logic       w_busy;
    logic       w_illegal;

    // Engine select of the latched opcode; zero with w_nop low means illegal.
    always_comb begin
        w_eng = 3'b000;
        w_nop = 1'b0;
        unique case (r_op)
            OP_LINE: w_eng = 3'b001;
            OP_ARC:  w_eng = 3'b010;
            OP_FILL: w_eng = 3'b100;
            OP_NOP:  w_nop = 1'b1;
            default: w_eng = 3'b000;
        endcase
    end

    assign w_take = (r_state == S_IDLE) && !bus.fifo_empty_i && !bus.stall_i;
    assign w_done = |(bus.done_i & w_eng);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_take) w_next = S_DECODE;
            S_DECODE: w_next = (w_eng != 3'b000) ? S_ISSUE : S_IDLE;
            S_ISSUE:  w_next = S_BUSY;
            S_BUSY:   if (w_done) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs are forced low while reset is held, even with a non-empty FIFO.
    always_comb begin
        w_pop     = 1'b0;
        w_start   = 3'b000;
        w_busy    = 1'b0;
        w_illegal = 1'b0;
        if (!rst) begin
            w_pop     = w_take;
            w_busy    = (r_state != S_IDLE);
            w_start   = (r_state == S_ISSUE) ? w_eng : 3'b000;
            w_illegal = (r_state == S_DECODE) && (w_eng == 3'b000) && !w_nop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op   <= '0;
            r_x1   <= '0;
            r_x2   <= '0;
            r_y1   <= '0;
            r_y2   <= '0;
            r_rad  <= '0;
            r_r    <= '0;
            r_g    <= '0;
            r_b    <= '0;
            r_quad <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_take) begin
                r_op   <= bus.opcode_i;
                r_x1   <= bus.x1_i;
                r_x2   <= bus.x2_i;
                r_y1   <= bus.y1_i;
                r_y2   <= bus.y2_i;
                r_rad  <= bus.rad_i;
                r_r    <= bus.r_i;
                r_g    <= bus.g_i;
                r_b    <= bus.b_i;
                r_quad <= bus.quad_i;
            end
            // Fill engine expects ascending corners on each axis.
            if (r_state == S_DECODE && r_op == OP_FILL) begin
                if (r_x1 > r_x2) begin
                    r_x1 <= r_x2;
                    r_x2 <= r_x1;
                end
                if (r_y1 > r_y2) begin
                    r_y1 <= r_y2;
                    r_y2 <= r_y1;
                end
            end
            if ((r_state == S_DECODE && w_nop) ||
                (r_state == S_BUSY && w_done)) begin
                r_cnt <= r_cnt + CNT_BITS'(1);
            end
        end
    end

    assign bus.pop_instruction_o = w_pop;
    assign bus.start_o           = w_start;
    assign bus.busy_o            = w_busy;
    assign bus.illegal_o         = w_illegal;
    assign bus.cmd_x1_o          = r_x1;
    assign bus.cmd_x2_o          = r_x2;
    assign bus.cmd_y1_o          = r_y1;
    assign bus.cmd_y2_o          = r_y2;
    assign bus.cmd_rad_o         = r_rad;
    assign bus.cmd_r_o           = r_r;
    assign bus.cmd_g_o           = r_g;
    assign bus.cmd_b_o           = r_b;
    assign bus.cmd_quad_o        = r_quad;
    assign bus.done_count_o      = r_cnt;
endmodule

// File: tb/tb_gpu_instruction_dispatch.sv
// Directed bench for gpu_instruction_dispatch: FIFO/engine stand-ins plus a
// transaction-level reference model compared against the DUT every cycle.
module tb_gpu_instruction_dispatch;
    localparam int W = 10;
    localparam int H = 10;
    localparam int C = 8;
    localparam int N = 16;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] x1;
        logic [W-1:0] x2;
        logic [H-1:0] y1;
        logic [H-1:0] y2;
        logic [W-1:0] rad;
        logic [C-1:0] r;
        logic [C-1:0] g;
        logic [C-1:0] b;
        logic [2:0]   quad;
    } instr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gpu_instruction_dispatch_if #(
        .W_BITS(W), .H_BITS(H), .C_BITS(C), .CNT_BITS(N)
    ) bus ();

    gpu_instruction_dispatch #(
        .W_BITS(W), .H_BITS(H), .C_BITS(C), .CNT_BITS(N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pop_total = 0;
    int start_total = 0;
    int illegal_total = 0;
    int last_pop_cyc = 0;
    int last_start_cyc = 0;
    instr_t snap;
    logic [2:0] snap_start;

    instr_t q[$];
    bit pop_seen;
    bit rst_seen;
    int eng_cnt = 0;
    logic [2:0] eng_bits = 3'b000;
    bit wrong_en = 1'b0;
    logic [2:0] wrong_bits = 3'b000;
    logic [2:0] spur_bits = 3'b000;

    bit m_inflight = 1'b0;
    int m_age = 0;
    instr_t m_cmd;
    logic [N-1:0] m_cnt = '0;

    function automatic logic [2:0] eng_of(logic [3:0] op);
        case (op)
            4'b0100: return 3'b001;
            4'b0010: return 3'b010;
            4'b0001: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic present();
        if (q.size() == 0) begin
            bus.fifo_empty_i = 1'b1;
            bus.opcode_i = '0;
            bus.x1_i = '0;
            bus.x2_i = '0;
            bus.y1_i = '0;
            bus.y2_i = '0;
            bus.rad_i = '0;
            bus.r_i = '0;
            bus.g_i = '0;
            bus.b_i = '0;
            bus.quad_i = '0;
        end else begin
            bus.fifo_empty_i = 1'b0;
            bus.opcode_i = q[0].op;
            bus.x1_i = q[0].x1;
            bus.x2_i = q[0].x2;
            bus.y1_i = q[0].y1;
            bus.y2_i = q[0].y2;
            bus.rad_i = q[0].rad;
            bus.r_i = q[0].r;
            bus.g_i = q[0].g;
            bus.b_i = q[0].b;
            bus.quad_i = q[0].quad;
        end
    endtask

    task automatic push(logic [3:0] op, int x1, int y1, int x2, int y2,
                        int col, int quad, int rad);
        instr_t it;
        it.op = op;
        it.x1 = W'(x1);
        it.x2 = W'(x2);
        it.y1 = H'(y1);
        it.y2 = H'(y2);
        it.rad = W'(rad);
        it.r = C'(col);
        it.g = C'(col + 1);
        it.b = C'(col + 2);
        it.quad = 3'(quad);
        q.push_back(it);
        present();
    endtask

    // Model: a popped instruction ages one step per cycle; age 1 decodes,
    // age 2 issues, age 3+ waits for the matching done bit.
    task automatic model_cycle();
        logic ep;
        logic [2:0] es;
        logic eb;
        logic ei;
        logic [2:0] e;
        ep = 1'b0;
        es = 3'b000;
        eb = 1'b0;
        ei = 1'b0;
        e = eng_of(m_cmd.op);
        if (!rst) begin
            if (!m_inflight) begin
                ep = !bus.fifo_empty_i && !bus.stall_i;
            end else begin
                eb = 1'b1;
                if (m_age == 1) ei = (e == 3'b000) && (m_cmd.op != 4'b0000);
                if (m_age == 2) es = e;
            end
        end
        chk("pop", 32'(bus.pop_instruction_o), 32'(ep));
        chk("start", 32'(bus.start_o), 32'(es));
        chk("busy", 32'(bus.busy_o), 32'(eb));
        chk("illegal", 32'(bus.illegal_o), 32'(ei));
        chk("count", 32'(bus.done_count_o), 32'(m_cnt));
        chk("cmd_x1", 32'(bus.cmd_x1_o), 32'(m_cmd.x1));
        chk("cmd_x2", 32'(bus.cmd_x2_o), 32'(m_cmd.x2));
        chk("cmd_y1", 32'(bus.cmd_y1_o), 32'(m_cmd.y1));
        chk("cmd_y2", 32'(bus.cmd_y2_o), 32'(m_cmd.y2));
        chk("cmd_rad", 32'(bus.cmd_rad_o), 32'(m_cmd.rad));
        chk("cmd_rgb", {8'h0, bus.cmd_r_o, bus.cmd_g_o, bus.cmd_b_o},
            {8'h0, m_cmd.r, m_cmd.g, m_cmd.b});
        chk("cmd_quad", 32'(bus.cmd_quad_o), 32'(m_cmd.quad));

        cyc++;
        pop_seen = bus.pop_instruction_o;
        rst_seen = rst;
        if (bus.pop_instruction_o) begin
            pop_total++;
            last_pop_cyc = cyc;
        end
        if (bus.illegal_o) illegal_total++;
        if (bus.start_o != 3'b000) begin
            start_total++;
            last_start_cyc = cyc;
            snap_start = bus.start_o;
            snap.x1 = bus.cmd_x1_o;
            snap.x2 = bus.cmd_x2_o;
            snap.y1 = bus.cmd_y1_o;
            snap.y2 = bus.cmd_y2_o;
            eng_bits = bus.start_o;
            eng_cnt = 3;
        end

        if (rst) begin
            m_inflight = 1'b0;
            m_cnt = '0;
            m_cmd = '{default: '0};
        end else if (!m_inflight) begin
            if (ep) begin
                m_inflight = 1'b1;
                m_age = 1;
                m_cmd = q[0];
            end
        end else if (m_age == 1) begin
            if (m_cmd.op == 4'b0000) begin
                m_cnt = m_cnt + 1'b1;
                m_inflight = 1'b0;
            end else if (e == 3'b000) begin
                m_inflight = 1'b0;
            end else begin
                m_age = 2;
                if (m_cmd.op == 4'b0001) begin
                    logic [W-1:0] tx;
                    logic [H-1:0] ty;
                    if (m_cmd.x1 > m_cmd.x2) begin
                        tx = m_cmd.x1;
                        m_cmd.x1 = m_cmd.x2;
                        m_cmd.x2 = tx;
                    end
                    if (m_cmd.y1 > m_cmd.y2) begin
                        ty = m_cmd.y1;
                        m_cmd.y1 = m_cmd.y2;
                        m_cmd.y2 = ty;
                    end
                end
            end
        end else if (m_age == 2) begin
            m_age = 3;
        end else if ((bus.done_i & e) != 3'b000) begin
            m_cnt = m_cnt + 1'b1;
            m_inflight = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        if (pop_seen && q.size() > 0) void'(q.pop_front());
        bus.done_i = 3'b000;
        if (rst_seen) begin
            eng_cnt = 0;
        end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) bus.done_i = eng_bits;
            else if (eng_cnt == 1 && wrong_en) bus.done_i = wrong_bits;
        end else begin
            bus.done_i = spur_bits;
        end
        present();
    endtask

    task automatic wait_idle(int budget);
        int n;
        n = 0;
        step();
        while ((m_inflight || q.size() > 0 || eng_cnt > 0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_idle: timed out after %0d cycles, required idle", n);
        end
    endtask

    initial begin
        int p0;
        int s0;
        int i0;
        int n;
        m_cmd = '{default: '0};
        snap = '{default: '0};
        snap_start = 3'b000;
        bus.stall_i = 1'b0;
        bus.done_i = 3'b000;
        present();

        push(4'b0100, 0, 0, 10, 10, 32, 1, 0);
        step();
        step();
        chk("reset_pop_total", 32'(pop_total), 32'd0);
        chk("reset_count", 32'(bus.done_count_o), 32'd0);
        rst = 1'b0;

        wait_idle(40);
        chk("line_latency", 32'(last_start_cyc - last_pop_cyc), 32'd2);
        chk("line_start", 32'(snap_start), 32'b001);
        chk("line_x2", 32'(snap.x2), 32'd10);
        chk("line_count", 32'(bus.done_count_o), 32'd1);

        push(4'b0001, 20, 7, 5, 3, 9, 2, 4);
        wait_idle(40);
        chk("fill_x1", 32'(snap.x1), 32'd5);
        chk("fill_x2", 32'(snap.x2), 32'd20);
        chk("fill_y1", 32'(snap.y1), 32'd3);
        chk("fill_y2", 32'(snap.y2), 32'd7);
        chk("fill_start", 32'(snap_start), 32'b100);
        chk("fill_count", 32'(bus.done_count_o), 32'd2);

        spur_bits = 3'b111;
        p0 = pop_total;
        s0 = start_total;
        i0 = illegal_total;
        push(4'b1111, 1, 2, 3, 4, 5, 6, 7);
        wait_idle(40);
        chk("illegal_pops", 32'(pop_total - p0), 32'd1);
        chk("illegal_pulses", 32'(illegal_total - i0), 32'd1);
        chk("illegal_nostart", 32'(start_total - s0), 32'd0);
        chk("illegal_count", 32'(bus.done_count_o), 32'd2);
        push(4'b0000, 0, 0, 0, 0, 0, 0, 0);
        wait_idle(40);
        chk("nop_count", 32'(bus.done_count_o), 32'd3);
        chk("nop_nostart", 32'(start_total - s0), 32'd0);
        spur_bits = 3'b000;

        bus.stall_i = 1'b1;
        p0 = pop_total;
        push(4'b0010, 100, 200, 300, 400, 77, 5, 63);
        for (int k = 0; k < 5; k++) step();
        chk("stall_nopop", 32'(pop_total - p0), 32'd0);
        bus.stall_i = 1'b0;
        wrong_en = 1'b1;
        wrong_bits = 3'b001;
        wait_idle(40);
        wrong_en = 1'b0;
        chk("arc_start", 32'(snap_start), 32'b010);
        chk("arc_count", 32'(bus.done_count_o), 32'd4);

        push(4'b0100, 1, 1, 2, 2, 3, 0, 0);
        n = 0;
        while (!(m_inflight && m_age == 3) && n < 20) begin
            step();
            n++;
        end
        chk("reach_busy", 32'(n < 20), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midreset_count", 32'(bus.done_count_o), 32'd0);
        chk("midreset_busy", 32'(bus.busy_o), 32'd0);
        chk("midreset_x2", 32'(bus.cmd_x2_o), 32'd0);

        p0 = pop_total;
        for (int k = 0; k < 8; k++) push(4'b0100, k, k + 1, 20 - k, 30 - k, k * 3, k, k);
        wait_idle(300);
        chk("burst_pops", 32'(pop_total - p0), 32'd8);
        chk("burst_count", 32'(bus.done_count_o), 32'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
